// File: rtl/mem_merger.sv
// ---------------------------------------------------------------------------
// mem_merger
//
// Merges the data-side (D) and instruction-side (I) access paths onto one
// shared memory port. An IDLE/BUSY/RESP state machine grants one requester
// at a time and holds its registered access on the shared port until the
// memory acknowledges or a watchdog expires. The result comes back as one
// word plus a D/I selector and a one-cycle valid strobe. These outputs feed
// the D/I splitter on the far side of the memory.
//
// Optional feature macro: MERGER_ROUND_ROBIN_EN
//    undefined : D has fixed priority over I on a simultaneous request.
//    defined   : the side that was not granted last wins a contest, and
//                D wins the first contest after reset.
//
// Parameters
//    bit_width  : data width
//    addr_width : address width
//    timeout    : BUSY cycles without an ack before aborting (>= 1)
//
// Ports
//    clk, rst                : clock, asynchronous active-high reset
//    d_req/d_we/d_addr/d_wdata : D-side level request and access fields
//    i_req/i_addr            : I-side level read request and address
//    mem_req/mem_we/mem_addr/mem_wdata : shared memory port (registered)
//    mem_ack/mem_rdata       : memory completion and read data
//    out_data                : returned word (0 for writes and aborts)
//    out_valid               : one-cycle completion strobe
//    selector                : owner of the current or last access, 0=D 1=I
//    err                     : timeout abort, only together with out_valid
// ---------------------------------------------------------------------------
module mem_merger #(
   parameter int bit_width  = 8,
   parameter int addr_width = 8,
   parameter int timeout    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [addr_width-1:0] d_addr,
   input  logic [bit_width-1:0]  d_wdata,
   input  logic                  i_req,
   input  logic [addr_width-1:0] i_addr,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [addr_width-1:0] mem_addr,
   output logic [bit_width-1:0]  mem_wdata,
   input  logic                  mem_ack,
   input  logic [bit_width-1:0]  mem_rdata,
   output logic [bit_width-1:0]  out_data,
   output logic                  out_valid,
   output logic                  selector,
   output logic                  err
);

   // Wide enough to hold the value `timeout` itself.
   localparam int cnt_w = (timeout < 1) ? 1 : $clog2(timeout + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [addr_width-1:0] mem_addr_q, mem_addr_d;
   logic [bit_width-1:0]  mem_wdata_q, mem_wdata_d;
   logic [bit_width-1:0]  out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  selector_q, selector_d;
   logic                  err_q, err_d;
   logic [cnt_w-1:0]      cnt_q, cnt_d;

   logic                  take_d;
   logic                  take_i;

`ifdef MERGER_ROUND_ROBIN_EN
   // Side granted most recently: 0 = D, 1 = I.
   logic                  last_grant_q, last_grant_d;
`endif

   // Arbitration between the two requesters for the IDLE grant.
   always_comb begin
      take_d = 1'b0;
      take_i = 1'b0;
`ifdef MERGER_ROUND_ROBIN_EN
      if (d_req && i_req) begin
         // On a contest the side that did not win last time goes first.
         if (last_grant_q) begin
            take_d = 1'b1;
         end else begin
            take_i = 1'b1;
         end
      end else begin
         take_d = d_req;
         take_i = i_req;
      end
`else
      take_d = d_req;
      take_i = i_req && !d_req;
`endif
   end

   // Next-state and next-output computation. Every output is a flop, so
   // nothing here reaches a port without passing through a register.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      selector_d  = selector_q;
      err_d       = 1'b0;
      cnt_d       = cnt_q;
`ifdef MERGER_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (take_d) begin
               mem_addr_d  = d_addr;
               mem_we_d    = d_we;
               mem_wdata_d = d_wdata;
               selector_d  = 1'b0;
               mem_req_d   = 1'b1;
               cnt_d       = '0;
               state_d     = BUSY;
`ifdef MERGER_ROUND_ROBIN_EN
               last_grant_d = 1'b0;
`endif
            end else if (take_i) begin
               // The I side only reads, so the write fields are cleared.
               mem_addr_d  = i_addr;
               mem_we_d    = 1'b0;
               mem_wdata_d = '0;
               selector_d  = 1'b1;
               mem_req_d   = 1'b1;
               cnt_d       = '0;
               state_d     = BUSY;
`ifdef MERGER_ROUND_ROBIN_EN
               last_grant_d = 1'b1;
`endif
            end
         end

         BUSY: begin
            // An ack arriving on the expiry cycle still wins over the abort.
            if (mem_ack) begin
               out_data_d  = mem_we_q ? '0 : mem_rdata;
               mem_req_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = RESP;
            end else if (cnt_q == cnt_w'(timeout)) begin
               out_data_d  = '0;
               err_d       = 1'b1;
               mem_req_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + cnt_w'(1);
            end
         end

         RESP: begin
            // The strobe lasts a single cycle; requests wait for IDLE.
            state_d = IDLE;
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers. Reset clears mem_req at once, which drops
   // any access in flight without producing a completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         selector_q  <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
`ifdef MERGER_ROUND_ROBIN_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         selector_q  <= selector_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
`ifdef MERGER_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign selector  = selector_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_merger.sv
// ---------------------------------------------------------------------------
// tb_mem_merger
//
// Self-checking bench for mem_merger. Single accesses come from a vector
// table; the bench plays the memory, acking after a per-vector delay or
// never. Expected completions go into a scoreboard queue when a request is
// driven and are popped when out_valid appears. Hand-written sequences
// cover arbitration order, ack while idle, and reset during an access.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_merger;

   localparam int BW = 8;
   localparam int AW = 8;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [BW-1:0] d_wdata;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [BW-1:0] mem_wdata;
   logic          mem_ack;
   logic [BW-1:0] mem_rdata;
   logic [BW-1:0] out_data;
   logic          out_valid;
   logic          selector;
   logic          err;

   int vecCount  = 0;
   int missCount = 0;

   typedef struct {
      string     name;
      bit        isI;
      bit        we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      int        ackDelay;
      logic [7:0] expData;
      bit        expErr;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       sel;
      logic       err;
   } resp_t;

   resp_t sb[$];
   vec_t  vecs[9];
   logic  expOrder[3];

   mem_merger #(
      .bit_width (BW),
      .addr_width(AW),
      .timeout   (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .out_data (out_data),
      .out_valid(out_valid),
      .selector (selector),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Hard stop in case some wait below is never satisfied.
   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "[TB] global timeout");
   end

   // Generic comparison: counts every check and reports a miss.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Pop the oldest expected completion and compare it with the outputs.
   task automatic popResponse(input string tag);
      resp_t r;
      if (sb.size() == 0) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL %s: out_valid with empty scoreboard", tag);
      end else begin
         r = sb.pop_front();
         checkOutput({tag, " out_data"}, 32'(out_data), 32'(r.data));
         checkOutput({tag, " selector"}, 32'(selector), 32'(r.sel));
         checkOutput({tag, " err"}, 32'(err), 32'(r.err));
      end
   endtask

   // Drive one access, act as the memory, and check the completion.
   task automatic applyStimulus(input vec_t v);
      int  t;
      int  expLat;
      bit  seenReq;
      bit  done;
      expLat  = (v.ackDelay < 0) ? TO + 1 : v.ackDelay + 1;
      seenReq = 1'b0;
      done    = 1'b0;
      t       = 0;
      @(negedge clk);
      if (v.isI) begin
         i_req  = 1'b1;
         i_addr = v.addr;
      end else begin
         d_req   = 1'b1;
         d_we    = v.we;
         d_addr  = v.addr;
         d_wdata = v.wdata;
      end
      sb.push_back('{data: v.expData, sel: v.isI, err: v.expErr});
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = 8'hEE;
         if (seenReq) t++;
         if (out_valid) begin
            popResponse(v.name);
            checkOutput({v.name, " valid_latency"}, 32'(t), 32'(expLat));
            checkOutput({v.name, " mem_req_low"}, 32'(mem_req), 32'd0);
            d_req = 1'b0;
            i_req = 1'b0;
            done  = 1'b1;
         end else if (!seenReq && mem_req) begin
            seenReq = 1'b1;
            t       = 0;
            checkOutput({v.name, " req_latency"}, 32'(c), 32'd0);
            checkOutput({v.name, " mem_addr"}, 32'(mem_addr), 32'(v.addr));
            checkOutput({v.name, " mem_we"}, 32'(mem_we), v.isI ? 32'd0 : 32'(v.we));
            checkOutput({v.name, " mem_wdata"}, 32'(mem_wdata), v.isI ? 32'd0 : 32'(v.wdata));
         end else if (seenReq) begin
            checkOutput({v.name, " mem_req_held"}, 32'(mem_req), 32'd1);
         end
         if (seenReq && !done && v.ackDelay == t) begin
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
         end
      end
      if (!done) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL %s: no out_valid within cycle budget", v.name);
         d_req   = 1'b0;
         i_req   = 1'b0;
         mem_ack = 1'b0;
         if (sb.size() > 0) void'(sb.pop_front());
      end
      // Strobe lasts one cycle; result and owner hold afterwards.
      @(negedge clk);
      checkOutput({v.name, " valid_one_cycle"}, 32'(out_valid), 32'd0);
      checkOutput({v.name, " err_cleared"}, 32'(err), 32'd0);
      checkOutput({v.name, " idle_mem_req"}, 32'(mem_req), 32'd0);
      checkOutput({v.name, " out_data_hold"}, 32'(out_data), 32'(v.expData));
      checkOutput({v.name, " selector_hold"}, 32'(selector), 32'(v.isI));
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " mem_req"}, 32'(mem_req), 32'd0);
      checkOutput({tag, " mem_we"}, 32'(mem_we), 32'd0);
      checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
      checkOutput({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
      checkOutput({tag, " out_data"}, 32'(out_data), 32'd0);
      checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, " selector"}, 32'(selector), 32'd0);
      checkOutput({tag, " err"}, 32'(err), 32'd0);
   endtask

   initial begin
      bit found;
      rst       = 1'b1;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      i_req     = 1'b0;
      i_addr    = '0;
      mem_ack   = 1'b0;
      mem_rdata = 8'hEE;

`ifdef MERGER_ROUND_ROBIN_EN
      expOrder[0] = 1'b0;
      expOrder[1] = 1'b1;
      expOrder[2] = 1'b0;
`else
      expOrder[0] = 1'b0;
      expOrder[1] = 1'b0;
      expOrder[2] = 1'b0;
`endif

      //           name             isI   we    addr   wdata  rdata  delay expData err
      vecs[0] = '{"d_write_imm",    1'b0, 1'b1, 8'h40, 8'h3C, 8'h99, 0,  8'h00, 1'b0};
      vecs[1] = '{"i_read_ack2",    1'b1, 1'b0, 8'h12, 8'h00, 8'hA5, 2,  8'hA5, 1'b0};
      vecs[2] = '{"d_read_imm",     1'b0, 1'b0, 8'h81, 8'h77, 8'h5A, 0,  8'h5A, 1'b0};
      vecs[3] = '{"i_read_ack1",    1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 1,  8'hFF, 1'b0};
      vecs[4] = '{"d_write_tmo",    1'b0, 1'b1, 8'h07, 8'hFF, 8'h33, -1, 8'h00, 1'b1};
      vecs[5] = '{"i_read_tmo",     1'b1, 1'b0, 8'h08, 8'h00, 8'h44, -1, 8'h00, 1'b1};
      vecs[6] = '{"i_ack_on_expiry",1'b1, 1'b0, 8'h09, 8'h00, 8'h77, 15, 8'h77, 1'b0};
      vecs[7] = '{"d_ack_before_exp",1'b0,1'b0, 8'h0A, 8'h00, 8'hC3, 14, 8'hC3, 1'b0};
      vecs[8] = '{"d_write_ack3",   1'b0, 1'b1, 8'h00, 8'h01, 8'hF0, 3,  8'h00, 1'b0};

      // Reset state, held in reset and after release.
      repeat (2) @(negedge clk);
      checkResetValues("reset_held");
      rst = 1'b0;
      @(negedge clk);
      checkResetValues("reset_released");

      // Table of single accesses.
      for (int k = 0; k < 9; k++) begin
         applyStimulus(vecs[k]);
      end

      // mem_ack while idle must not produce anything.
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = 8'h11;
      repeat (2) begin
         @(negedge clk);
         checkOutput("idle_ack out_valid", 32'(out_valid), 32'd0);
         checkOutput("idle_ack mem_req", 32'(mem_req), 32'd0);
      end
      mem_ack   = 1'b0;
      mem_rdata = 8'hEE;

      // Both sides requesting continuously for three accesses.
      @(negedge clk);
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 8'h21;
      d_wdata = 8'h00;
      i_req   = 1'b1;
      i_addr  = 8'h31;
      for (int k = 0; k < 3; k++) begin
         found = 1'b0;
         for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (mem_req) found = 1'b1;
         end
         if (!found) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL arb_grant%0d: no mem_req within budget", k);
         end else begin
            checkOutput($sformatf("arb_grant%0d selector", k), 32'(selector), 32'(expOrder[k]));
            checkOutput($sformatf("arb_grant%0d mem_addr", k), 32'(mem_addr),
                        expOrder[k] ? 32'h31 : 32'h21);
            mem_ack   = 1'b1;
            mem_rdata = 8'h60 + 8'(k);
            sb.push_back('{data: 8'h60 + 8'(k), sel: expOrder[k], err: 1'b0});
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 8'hEE;
            if (out_valid) begin
               popResponse($sformatf("arb_resp%0d", k));
            end else begin
               vecCount++;
               missCount++;
               $display("[TB] FAIL arb_resp%0d: out_valid=%0d, expected 1", k, out_valid);
               if (sb.size() > 0) void'(sb.pop_front());
            end
            if (k == 2) begin
               d_req = 1'b0;
               i_req = 1'b0;
            end
         end
      end
      d_req = 1'b0;
      i_req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("arb_quiet mem_req", 32'(mem_req), 32'd0);
      end

      // Reset in the middle of an access.
      @(negedge clk);
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 8'h55;
      d_wdata = 8'hAA;
      @(negedge clk);
      checkOutput("rst_mid pre mem_req", 32'(mem_req), 32'd1);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 checkResetValues("rst_mid async");
      d_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         checkOutput("rst_mid no out_valid", 32'(out_valid), 32'd0);
         checkOutput("rst_mid no mem_req", 32'(mem_req), 32'd0);
      end
      applyStimulus('{"post_reset_read", 1'b1, 1'b0, 8'h12, 8'h00, 8'hA5, 2, 8'hA5, 1'b0});

      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
